// File: rtl/generador_tonos_n.sv
// Priority-keyed square-wave tone generator; 1-cycle input latency, free-running output with no backpressure.
// Optional sustain tail after key release is built when SUSTAIN_EN is defined.
module generador_tonos_n #(
  parameter int                            NUM_KEYS       = 7,
  parameter int                            DIV_WIDTH      = 21,
  parameter logic [NUM_KEYS*DIV_WIDTH-1:0] TABLA          = {21'd50619, 21'd56818, 21'd63776, 21'd71586,
                                                             21'd75843, 21'd85131, 21'd95556},
  parameter logic [24:0]                   SUSTAIN_CYCLES = 25'd5000000,
  localparam int                           SEL_W          = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_KEYS-1:0] teclas,
  input  logic [1:0]          octava,
  output logic                clk_out,
  output logic                activo,
  output logic [SEL_W-1:0]    nota
);

`ifdef SUSTAIN_EN
  typedef enum logic [1:0] {IDLE, TONO, HOLD} state_t;
`else
  typedef enum logic [1:0] {IDLE, TONO} state_t;
`endif

  state_t                state, state_n;
  logic [NUM_KEYS-1:0]   teclas_r;
  logic [1:0]            octava_r, oct_q, oct_n;
  logic [SEL_W-1:0]      sel_in, sel_q, sel_n, nota_n;
  logic [DIV_WIDTH-1:0]  cnt, cnt_n, tab_entry, shifted, hp;
  logic                  any_key, restart, run, clk_n, act_n;
`ifdef SUSTAIN_EN
  logic [24:0]           tmr, tmr_n;
`endif

  // Lowest-index pressed key wins
  always_comb begin
    sel_in = '0;
    for (int i = NUM_KEYS - 1; i >= 0; i--) begin
      if (teclas_r[i]) sel_in = SEL_W'(i);
    end
    any_key = |teclas_r;
  end

  // Half-period follows the latched note, so a sustained tail keeps its pitch
  always_comb begin
    tab_entry = TABLA[int'(sel_q) * DIV_WIDTH +: DIV_WIDTH];
    shifted   = tab_entry >> oct_q;
    hp        = (shifted == '0) ? DIV_WIDTH'(1) : shifted;
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    clk_n   = clk_out;
    act_n   = activo;
    nota_n  = nota;
    sel_n   = sel_q;
    oct_n   = oct_q;
    restart = 1'b0;
    run     = 1'b0;
`ifdef SUSTAIN_EN
    tmr_n   = tmr;
`endif
    case (state)
      IDLE: begin
        if (any_key) begin
          state_n = TONO;
          restart = 1'b1;
        end
      end
      TONO: begin
        if (!any_key) begin
`ifdef SUSTAIN_EN
          state_n = HOLD;
          tmr_n   = '0;
          run     = 1'b1;
`else
          state_n = IDLE;
`endif
        end else if (sel_in != sel_q || octava_r != oct_q) begin
          restart = 1'b1;
        end else begin
          run = 1'b1;
        end
      end
`ifdef SUSTAIN_EN
      HOLD: begin
        if (any_key) begin
          state_n = TONO;
          if (sel_in != sel_q || octava_r != oct_q) restart = 1'b1;
          else                                      run     = 1'b1;
        end else if (25'(tmr + 1'b1) >= SUSTAIN_CYCLES) begin
          state_n = IDLE;
        end else begin
          tmr_n = tmr + 1'b1;
          run   = 1'b1;
        end
      end
`endif
      default: state_n = IDLE;
    endcase

    if (restart) begin
      cnt_n  = '0;
      clk_n  = 1'b0;
      act_n  = 1'b1;
      nota_n = sel_in;
      sel_n  = sel_in;
      oct_n  = octava_r;
    end else if (run) begin
      if (cnt == hp - 1'b1) begin
        cnt_n = '0;
        clk_n = ~clk_out;
      end else begin
        cnt_n = cnt + 1'b1;
      end
    end

    if (state_n == IDLE) begin
      cnt_n  = '0;
      clk_n  = 1'b0;
      act_n  = 1'b0;
      nota_n = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      teclas_r <= '0;
      octava_r <= '0;
      sel_q    <= '0;
      oct_q    <= '0;
      cnt      <= '0;
      clk_out  <= 1'b0;
      activo   <= 1'b0;
      nota     <= '0;
`ifdef SUSTAIN_EN
      tmr      <= '0;
`endif
    end else begin
      state    <= state_n;
      teclas_r <= teclas;
      octava_r <= octava;
      sel_q    <= sel_n;
      oct_q    <= oct_n;
      cnt      <= cnt_n;
      clk_out  <= clk_n;
      activo   <= act_n;
      nota     <= nota_n;
`ifdef SUSTAIN_EN
      tmr      <= tmr_n;
`endif
    end
  end

endmodule

// File: tb/tb_generador_tonos_n.sv
// Directed bench for generador_tonos_n with a shortened tone table so every period fits a short run.
module tb_generador_tonos_n;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] teclas;
  logic [1:0] octava;
  logic       clk_out;
  logic       activo;
  logic [2:0] nota;

  int checks = 0;
  int errors = 0;
  int n;

  always #5 clk = ~clk;

  // Entries 6..0 = 3, 15, 7, 12, 9, 1, 20 half-period cycles
  generador_tonos_n #(
    .NUM_KEYS      (7),
    .DIV_WIDTH     (21),
    .TABLA         ({21'd3, 21'd15, 21'd7, 21'd12, 21'd9, 21'd1, 21'd20}),
    .SUSTAIN_CYCLES(25'd1000)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .teclas (teclas),
    .octava (octava),
    .clk_out(clk_out),
    .activo (activo),
    .nota   (nota)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int cnt);
    repeat (cnt) @(negedge clk);
  endtask

  // Negedges until clk_out is next seen rising; -1 if it never does
  task automatic wait_rise(output int res);
    logic last;
    last = clk_out;
    res  = -1;
    for (int i = 1; i <= 200; i++) begin
      @(negedge clk);
      if (clk_out === 1'b1 && last === 1'b0) begin
        res = i;
        break;
      end
      last = clk_out;
    end
  endtask

  initial begin
    reset  = 1'b1;
    teclas = '0;
    octava = '0;
    tick(2);
    check("reset_clk_out", 32'(clk_out), 0);
    check("reset_activo", 32'(activo), 0);
    check("reset_nota", 32'(nota), 0);
    reset = 1'b0;
    tick(3);
    check("idle_clk_out", 32'(clk_out), 0);
    check("idle_activo", 32'(activo), 0);

    // Single key 5, hp = 15
    teclas = 7'b0100000;
    tick(2);
    check("k5_activo", 32'(activo), 1);
    check("k5_nota", 32'(nota), 5);
    check("k5_clk_low", 32'(clk_out), 0);
    wait_rise(n); check("k5_first_rise", n, 15);
    wait_rise(n); check("k5_period", n, 30);

    // Keys 0 and 5 together: key 0 wins, hp = 20
    teclas = 7'b0100001;
    tick(2);
    check("k05_nota", 32'(nota), 0);
    check("k05_restart_low", 32'(clk_out), 0);
    wait_rise(n); check("k05_first_rise", n, 20);
    wait_rise(n); check("k05_period", n, 40);

    // Release key 0: back to key 5 with a fresh phase
    teclas = 7'b0100000;
    tick(2);
    check("k5b_nota", 32'(nota), 5);
    check("k5b_restart_low", 32'(clk_out), 0);
    wait_rise(n); check("k5b_first_rise", n, 15);
    wait_rise(n); check("k5b_period", n, 30);

    // Key 0 at octave 2: hp = 20 >> 2 = 5
    teclas = 7'b0000001;
    octava = 2'd2;
    tick(2);
    check("oct2_nota", 32'(nota), 0);
    wait_rise(n); check("oct2_first_rise", n, 5);
    wait_rise(n); check("oct2_period", n, 10);

    // Octave change while clk_out is high restarts low, hp = 10
    octava = 2'd1;
    tick(2);
    check("oct1_restart_low", 32'(clk_out), 0);
    wait_rise(n); check("oct1_first_rise", n, 10);
    wait_rise(n); check("oct1_period", n, 20);

    // Table entry 1 at octave 0: toggles every cycle
    octava = 2'd0;
    teclas = 7'b0000010;
    tick(2);
    check("hp1_nota", 32'(nota), 1);
    check("hp1_start_low", 32'(clk_out), 0);
    tick(1); check("hp1_toggle_hi", 32'(clk_out), 1);
    tick(1); check("hp1_toggle_lo", 32'(clk_out), 0);
    wait_rise(n); check("hp1_rise", n, 1);
    wait_rise(n); check("hp1_period", n, 2);

    // Keys 4 and 6, octave 3: 7 >> 3 = 0 clamps to 1
    teclas = 7'b1010000;
    octava = 2'd3;
    tick(2);
    check("clamp_nota", 32'(nota), 4);
    check("clamp_start_low", 32'(clk_out), 0);
    tick(1); check("clamp_toggle_hi", 32'(clk_out), 1);
    tick(1); check("clamp_toggle_lo", 32'(clk_out), 0);

    // Reset pulsed during the high phase of key 5
    octava = 2'd0;
    teclas = 7'b0100000;
    tick(2);
    wait_rise(n); check("rst_pre_rise", n, 15);
    #2 reset = 1'b1;
    #1;
    check("rst_async_clk_out", 32'(clk_out), 0);
    check("rst_async_activo", 32'(activo), 0);
    check("rst_async_nota", 32'(nota), 0);
    tick(2);
    reset = 1'b0;
    // One edge to register the key, one to enter TONO, then hp = 15 low cycles
    wait_rise(n); check("rst_resume_rise", n, 17);

    // Release: activo still high one cycle later, low the cycle after
    teclas = '0;
    tick(1);
    check("rel_activo_hold", 32'(activo), 1);
    tick(1);
    check("rel_activo", 32'(activo), 0);
    check("rel_clk_out", 32'(clk_out), 0);
    check("rel_nota", 32'(nota), 0);
    tick(20);
    check("rel_idle_clk_out", 32'(clk_out), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
